// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypassing, load-use hazard detection
// and a saturating count of load-use stall bubbles.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic [2:0]  id_rd,
  input  logic [15:0] id_rs_data,
  input  logic [15:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        id_use_imm,
  input  logic [3:0]  id_shamt,
  input  logic [2:0]  id_alu_control,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        flush,
  input  logic [15:0] ex_alu_result,
  input  logic        mem_reg_write,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_result,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [3:0]  ex_shamt,
  output logic [2:0]  ex_alu_control,
  output logic        ex_valid,
  output logic [2:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [15:0] ex_store_data,
  output logic        stall,
  output logic [15:0] stall_count
);

  logic        load_use;
  logic [15:0] fwd_rs;
  logic [15:0] fwd_rt;

  // A load in EX has no result yet, so it can never be an EX bypass source.
  function automatic logic [15:0] bypass(input logic [2:0] idx, input logic [15:0] reg_data);
    logic [15:0] result;
    result = reg_data;
    if (idx != 3'd0) begin
      if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == idx))
        result = ex_alu_result;
      else if (mem_reg_write && (mem_rd == idx))
        result = mem_result;
      else if (wb_reg_write && (wb_rd == idx))
        result = wb_result;
    end
    return result;
  endfunction

  always_comb begin
    fwd_rs   = bypass(id_rs, id_rs_data);
    fwd_rt   = bypass(id_rt, id_rt_data);
    load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 3'd0) &&
               ((id_rs == ex_rd) || ((id_rt == ex_rd) && (!id_use_imm || id_mem_write)));
    stall    = load_use && !flush;
  end

  // Flush beats stall; both leave a bubble, only a stall is counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_a           <= '0;
      ex_b           <= '0;
      ex_shamt       <= '0;
      ex_alu_control <= '0;
      ex_valid       <= 1'b0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_store_data  <= '0;
      stall_count    <= '0;
    end else if (flush || load_use) begin
      ex_a           <= '0;
      ex_b           <= '0;
      ex_shamt       <= '0;
      ex_alu_control <= 3'b000;
      ex_valid       <= 1'b0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_store_data  <= '0;
      if (!flush && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end else begin
      ex_a           <= fwd_rs;
      ex_b           <= id_use_imm ? id_imm : fwd_rt;
      ex_shamt       <= id_shamt;
      ex_alu_control <= id_alu_control;
      ex_valid       <= id_valid;
      ex_rd          <= id_rd;
      ex_reg_write   <= id_valid && id_reg_write;
      ex_mem_read    <= id_valid && id_mem_read;
      ex_mem_write   <= id_valid && id_mem_write;
      ex_store_data  <= fwd_rt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass priority, load-use stalls, r0
// protection, immediates/stores, flush priority, reset and counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [3:0]  id_shamt;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [15:0] ex_alu_result;
  logic        mem_reg_write;
  logic [2:0]  mem_rd;
  logic [15:0] mem_result;
  logic        wb_reg_write;
  logic [2:0]  wb_rd;
  logic [15:0] wb_result;
  logic [15:0] ex_a, ex_b, ex_store_data, stall_count;
  logic [3:0]  ex_shamt;
  logic [2:0]  ex_alu_control, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_shamt(id_shamt), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_alu_result(ex_alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_alu_control(ex_alu_control),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0;
    id_shamt = 0; id_alu_control = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    flush = 0; ex_alu_result = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode slot holds "lw r2": a load that writes r2.
  task automatic drive_lw_r2();
    id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 3'd2;
    id_use_imm = 1; id_imm = 16'h0004;
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 0;
  endtask

  // Decode slot holds an ALU op reading r2, dependent on a load in EX.
  task automatic drive_use_r2();
    id_valid = 1; id_rs = 3'd2; id_rt = 3'd1; id_rd = 3'd6;
    id_use_imm = 0; id_rs_data = 16'h1111;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #2;
    chk("reset_ex_valid", {15'd0, ex_valid}, 16'd0);
    chk("reset_ex_a", ex_a, 16'd0);
    chk("reset_stall_count", stall_count, 16'd0);
    chk("reset_stall", {15'd0, stall}, 16'd0);
    tick();
    reset = 0;

    // Bypass priority on r3: EX > MEM > WB > register file
    id_valid = 1; id_rd = 3'd3; id_reg_write = 1; id_alu_control = 3'b010;
    tick();
    chk("add_ex_valid", {15'd0, ex_valid}, 16'd1);
    chk("add_ex_rd", {13'd0, ex_rd}, 16'd3);
    chk("add_alu_ctrl", {13'd0, ex_alu_control}, 16'd2);
    ex_alu_result = 16'h0011;
    mem_reg_write = 1; mem_rd = 3'd3; mem_result = 16'h0022;
    wb_reg_write = 1; wb_rd = 3'd3; wb_result = 16'h0033;
    id_rs = 3'd3; id_rs_data = 16'h0AAA; id_rd = 3'd5;
    tick();
    chk("fwd_ex_prio", ex_a, 16'h0011);
    id_rt = 3'd3; id_rt_data = 16'h0BBB;
    tick();
    chk("fwd_mem_prio", ex_a, 16'h0022);
    chk("fwd_mem_rt", ex_b, 16'h0022);
    chk("fwd_mem_store", ex_store_data, 16'h0022);
    mem_reg_write = 0;
    tick();
    chk("fwd_wb_prio", ex_a, 16'h0033);
    wb_reg_write = 0;
    tick();
    chk("fwd_none", ex_a, 16'h0AAA);
    chk("fwd_none_rt", ex_b, 16'h0BBB);

    // Load-use stall then MEM bypass of the loaded value
    clear_inputs();
    drive_lw_r2();
    tick();
    chk("lw_ex_mem_read", {15'd0, ex_mem_read}, 16'd1);
    drive_use_r2();
    #1;
    chk("lu_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("lu_bubble_valid", {15'd0, ex_valid}, 16'd0);
    chk("lu_bubble_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("lu_count1", stall_count, 16'd1);
    chk("lu_stall_drop", {15'd0, stall}, 16'd0);
    mem_reg_write = 1; mem_rd = 3'd2; mem_result = 16'hBEEF;
    tick();
    chk("lu_bypass_a", ex_a, 16'hBEEF);
    chk("lu_valid", {15'd0, ex_valid}, 16'd1);
    chk("lu_rd", {13'd0, ex_rd}, 16'd6);

    // r0 is never bypassed and never stalls
    clear_inputs();
    mem_reg_write = 1; mem_rd = 3'd0; mem_result = 16'hFFFF;
    id_valid = 1; id_rs = 3'd0; id_rs_data = 16'h0000; id_rd = 3'd1; id_reg_write = 1;
    tick();
    chk("r0_no_bypass", ex_a, 16'h0000);
    clear_inputs();
    id_valid = 1; id_rd = 3'd0; id_reg_write = 1; id_mem_read = 1;
    tick();
    id_mem_read = 0; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd1;
    #1;
    chk("r0_no_stall", {15'd0, stall}, 16'd0);

    // rt hazard only matters for register operands or store data
    clear_inputs();
    drive_lw_r2();
    tick();
    id_valid = 1; id_rs = 3'd1; id_rt = 3'd2; id_rd = 3'd7; id_use_imm = 1;
    id_mem_read = 0; id_mem_write = 0;
    #1;
    chk("rt_imm_no_stall", {15'd0, stall}, 16'd0);
    id_mem_write = 1;
    #1;
    chk("rt_store_stall", {15'd0, stall}, 16'd1);
    flush = 1;
    #1;
    chk("flush_kills_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("flush_bubble", {15'd0, ex_valid}, 16'd0);
    chk("flush_count_hold", stall_count, 16'd1);

    // Immediate goes to ex_b, forwarded rt goes to store data
    clear_inputs();
    id_valid = 1; id_rs = 3'd1; id_rt = 3'd4; id_rt_data = 16'h0999;
    id_use_imm = 1; id_imm = 16'h0005; id_mem_write = 1;
    wb_reg_write = 1; wb_rd = 3'd4; wb_result = 16'h1234;
    tick();
    chk("imm_ex_b", ex_b, 16'h0005);
    chk("store_data_fwd", ex_store_data, 16'h1234);
    chk("store_mem_write", {15'd0, ex_mem_write}, 16'd1);

    // Invalid slot: controls squashed, other fields still captured
    clear_inputs();
    id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    id_shamt = 4'hA; id_alu_control = 3'b101;
    tick();
    chk("inv_valid", {15'd0, ex_valid}, 16'd0);
    chk("inv_ctrl", {13'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 16'd0);
    chk("inv_shamt", {12'd0, ex_shamt}, 16'h000A);
    chk("inv_alu_ctrl", {13'd0, ex_alu_control}, 16'd5);

    // Six more stalls bring the count to 7
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      drive_lw_r2();
      tick();
      drive_use_r2();
      tick();
    end
    drive_lw_r2();
    tick();
    chk("pre_reset_valid", {15'd0, ex_valid}, 16'd1);
    chk("pre_reset_count", stall_count, 16'd7);

    // Asynchronous reset between edges
    #2;
    reset = 1;
    #1;
    chk("async_rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("async_rst_count", stall_count, 16'd0);
    chk("async_rst_rd", {13'd0, ex_rd}, 16'd0);
    tick();
    chk("rst_hold_no_capture", {15'd0, ex_valid}, 16'd0);
    reset = 0;
    tick();
    chk("post_rst_capture", {15'd0, ex_mem_read}, 16'd1);

    // Saturation at 16'hFFFF
    force dut.stall_count = 16'hFFFF;
    #1;
    release dut.stall_count;
    #1;
    chk("sat_preset", stall_count, 16'hFFFF);
    drive_use_r2();
    #1;
    chk("sat_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("sat_hold", stall_count, 16'hFFFF);
    chk("sat_bubble", {15'd0, ex_valid}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
